// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses CMD_OP/CMD_FUN frames, issues one ALU op and sends the result as two TX bytes, low byte first.
// Issues 1 cycle after the last frame byte, TX strobes at +4/+5; TX holds while FIFO_FULL is high, and bytes arriving outside the frame states are dropped.
module alu_cmd_ctrl #(
    parameter int               DATA_W  = 8,
    parameter int               OUT_W   = 16,
    parameter int               TIMEOUT = 15,
    parameter logic [DATA_W-1:0] CMD_OP  = 8'hCC,
    parameter logic [DATA_W-1:0] CMD_FUN = 8'hDD
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [OUT_W-1:0]  ALU_OUT,
    input  logic              OUT_Valid,
    input  logic              FIFO_FULL,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              BUSY,
    output logic              ERR,
    output logic              RX_DROP
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, SEND_HI
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [OUT_W-1:0]    result, result_nxt;
    logic [DATA_W-1:0]   a_nxt, b_nxt, tx_dat_nxt;
    logic [3:0]          fun_nxt;
    logic                tx_vld_nxt, err_nxt, drop_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        result_nxt = result;
        a_nxt      = ALU_A;
        b_nxt      = ALU_B;
        fun_nxt    = ALU_FUN;
        tx_dat_nxt = TX_P_DATA;
        tx_vld_nxt = 1'b0;
        err_nxt    = 1'b0;
        drop_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD && RX_P_DATA == CMD_OP)       state_nxt = GET_A;
                else if (RX_D_VLD && RX_P_DATA == CMD_FUN) state_nxt = GET_FUN;
            end
            GET_A: if (RX_D_VLD) begin
                a_nxt     = RX_P_DATA;
                state_nxt = GET_B;
            end
            GET_B: if (RX_D_VLD) begin
                b_nxt     = RX_P_DATA;
                state_nxt = GET_FUN;
            end
            GET_FUN: if (RX_D_VLD) begin
                fun_nxt   = RX_P_DATA[3:0];
                state_nxt = ISSUE;
            end
            ISSUE: begin
                drop_nxt  = RX_D_VLD;
                cnt_nxt   = '0;
                state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                drop_nxt = RX_D_VLD;
                if (OUT_Valid) begin
                    result_nxt = ALU_OUT;
                    state_nxt  = SEND_LO;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    // cnt holds the count before this cycle's increment
                    if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            SEND_LO: begin
                drop_nxt = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_vld_nxt = 1'b1;
                    tx_dat_nxt = result[DATA_W-1:0];
                    state_nxt  = SEND_HI;
                end
            end
            SEND_HI: begin
                drop_nxt = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_vld_nxt = 1'b1;
                    tx_dat_nxt = result[OUT_W-1:DATA_W];
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt       <= '0;
            result    <= '0;
            ALU_EN    <= 1'b0;
            ALU_FUN   <= '0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
            RX_DROP   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            ALU_EN    <= (state_nxt == ISSUE);
            ALU_FUN   <= fun_nxt;
            ALU_A     <= a_nxt;
            ALU_B     <= b_nxt;
            TX_P_DATA <= tx_dat_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            BUSY      <= (state_nxt != IDLE);
            ERR       <= err_nxt;
            RX_DROP   <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: registered ALU model, frame-level reference, TX/pulse monitor.
module tb_alu_cmd_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_p_data = '0;
    logic        rx_d_vld = 1'b0;
    logic [15:0] alu_out;
    logic        out_valid;
    logic        fifo_full = 1'b0;
    logic        alu_en, tx_d_vld, busy, err, rx_drop;
    logic [3:0]  alu_fun;
    logic [7:0]  alu_a, alu_b, tx_p_data;

    int errors = 0;
    int checks = 0;

    alu_cmd_ctrl #(.DATA_W(8), .OUT_W(16), .TIMEOUT(TIMEOUT), .CMD_OP(8'hCC), .CMD_FUN(8'hDD)) dut (
        .CLK(clk), .RST(rst), .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
        .ALU_OUT(alu_out), .OUT_Valid(out_valid), .FIFO_FULL(fifo_full),
        .ALU_EN(alu_en), .ALU_FUN(alu_fun), .ALU_A(alu_a), .ALU_B(alu_b),
        .TX_P_DATA(tx_p_data), .TX_D_VLD(tx_d_vld), .BUSY(busy), .ERR(err), .RX_DROP(rx_drop)
    );

    always #5 clk = ~clk;

    // Environment ALU: 0 add, 1 sub, 2 mul, 3 div, anything else returns 0.
    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return (b == 0) ? 16'h0 : 16'(a) / 16'(b);
            default: return 16'h0;
        endcase
    endfunction

    logic alu_mute = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
        end else begin
            out_valid <= alu_en && !alu_mute;
            if (alu_en) alu_out <= alu_calc(alu_a, alu_b, alu_fun);
        end
    end

    // Monitor samples 1 time unit after each rising edge.
    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];
    int cyc = 0, drop_cnt = 0, err_cnt = 0, en_cnt = 0, en_cyc = 0, err_cyc = 0, viol = 0;
    logic [7:0] en_a = '0, en_b = '0;
    logic [3:0] en_fun = '0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_d_vld) begin
            tx_q.push_back(tx_p_data);
            tx_cyc_q.push_back(cyc);
            if (fifo_full) viol++;
        end
        if (rx_drop) drop_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (alu_en) begin
            en_cnt++;
            en_cyc = cyc;
            en_a   = alu_a;
            en_b   = alu_b;
            en_fun = alu_fun;
        end
    end

    // Reference state: operands the next CMD_FUN frame should reuse.
    logic [7:0] m_a = '0, m_b = '0;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_p_data = b;
        rx_d_vld  = 1'b1;
        @(negedge clk);
        rx_d_vld  = 1'b0;
    endtask

    task automatic send_frame(input bit op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] fb);
        if (op) begin
            send_byte(8'hCC);
            send_byte(a);
            send_byte(b);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(8'hDD);
        end
        send_byte(fb);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({alu_en, alu_fun, alu_a, alu_b, tx_p_data, tx_d_vld, busy, err, rx_drop} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b fun=%h a=%h b=%h tx=%h vld=%b busy=%b err=%b drop=%b want all 0",
                     alu_en, alu_fun, alu_a, alu_b, tx_p_data, tx_d_vld, busy, err, rx_drop);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_add;
        bit ok;
        int tb = tx_q.size();
        int eb = en_cnt;
        send_frame(1'b1, 8'h05, 8'h03, 8'h00);
        wait_idle(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_idle busy stuck want idle within 20 cycles"); end
        checks++;
        if (en_cnt - eb != 1 || en_a !== 8'h05 || en_b !== 8'h03 || en_fun !== 4'h0) begin
            errors++;
            $display("FAIL add_issue pulses=%0d a=%h b=%h fun=%h want 1 05 03 0", en_cnt - eb, en_a, en_b, en_fun);
        end
        checks++;
        if (tx_q.size() != tb + 2 || tx_q[tb] !== 8'h08 || tx_q[tb+1] !== 8'h00) begin
            errors++;
            $display("FAIL add_tx got %0d bytes want 08 00", tx_q.size() - tb);
        end else begin
            checks++;
            // ISSUE is +1 after the last byte, TX strobes at +4 and +5.
            if (tx_cyc_q[tb] - en_cyc != 3 || tx_cyc_q[tb+1] - tx_cyc_q[tb] != 1) begin
                errors++;
                $display("FAIL add_latency tx0-en=%0d tx1-tx0=%0d want 3 1",
                         tx_cyc_q[tb] - en_cyc, tx_cyc_q[tb+1] - tx_cyc_q[tb]);
            end
        end
    endtask

    task automatic test_mul_fun;
        bit ok;
        int tb = tx_q.size();
        send_frame(1'b1, 8'hFF, 8'hFF, 8'h02);
        wait_idle(20, ok);
        checks++;
        if (!ok || tx_q.size() != tb + 2 || tx_q[tb] !== 8'h01 || tx_q[tb+1] !== 8'hFE) begin
            errors++;
            $display("FAIL mul_tx ok=%b bytes=%0d want 01 FE", ok, tx_q.size() - tb);
        end
        tb = tx_q.size();
        send_frame(1'b0, 8'h00, 8'h00, 8'h01);
        wait_idle(20, ok);
        checks++;
        if (en_a !== 8'hFF || en_b !== 8'hFF || en_fun !== 4'h1) begin
            errors++;
            $display("FAIL fun_only_operands a=%h b=%h fun=%h want FF FF 1", en_a, en_b, en_fun);
        end
        checks++;
        if (!ok || tx_q.size() != tb + 2 || tx_q[tb] !== 8'h00 || tx_q[tb+1] !== 8'h00) begin
            errors++;
            $display("FAIL fun_only_tx ok=%b bytes=%0d want 00 00", ok, tx_q.size() - tb);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int tb = tx_q.size();
        int drop_at;
        fifo_full = 1'b1;
        send_frame(1'b1, 8'h05, 8'h03, 8'h00);
        repeat (2 + 5) @(negedge clk);
        checks++;
        if (tx_q.size() != tb || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold strobes=%0d busy=%b want 0 1", tx_q.size() - tb, busy);
        end
        fifo_full = 1'b0;
        drop_at   = cyc;
        wait_idle(20, ok);
        checks++;
        if (!ok || tx_q.size() != tb + 2 || tx_q[tb] !== 8'h08 || tx_q[tb+1] !== 8'h00) begin
            errors++;
            $display("FAIL bp_tx ok=%b bytes=%0d want 08 00", ok, tx_q.size() - tb);
        end else begin
            checks++;
            if (tx_cyc_q[tb] != drop_at + 1 || tx_cyc_q[tb+1] != drop_at + 2) begin
                errors++;
                $display("FAIL bp_timing tx at +%0d +%0d want +1 +2",
                         tx_cyc_q[tb] - drop_at, tx_cyc_q[tb+1] - drop_at);
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bp_full_strobe count=%0d want 0", viol); end
    endtask

    task automatic test_timeout;
        bit ok;
        int tb = tx_q.size();
        int eb = err_cnt;
        alu_mute = 1'b1;
        send_frame(1'b1, 8'h10, 8'h20, 8'h00);
        wait_idle(40, ok);
        alu_mute = 1'b0;
        checks++;
        if (!ok || err_cnt - eb != 1) begin
            errors++;
            $display("FAIL timeout_err ok=%b pulses=%0d want 1 1", ok, err_cnt - eb);
        end
        // ERR is registered on the edge TIMEOUT edges after the one that samples ALU_EN.
        checks++;
        if (err_cyc - en_cyc != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_delay got %0d want %0d", err_cyc - en_cyc, TIMEOUT + 1);
        end
        checks++;
        if (tx_q.size() != tb) begin errors++; $display("FAIL timeout_no_tx got %0d strobes want 0", tx_q.size() - tb); end
        send_frame(1'b1, 8'h10, 8'h20, 8'h00);
        wait_idle(20, ok);
        checks++;
        if (!ok || tx_q.size() != tb + 2 || tx_q[tb] !== 8'h30 || tx_q[tb+1] !== 8'h00) begin
            errors++;
            $display("FAIL timeout_recover ok=%b bytes=%0d want 30 00", ok, tx_q.size() - tb);
        end
    endtask

    task automatic test_drop;
        bit ok;
        int tb = tx_q.size();
        int db = drop_cnt;
        int eb = en_cnt;
        send_frame(1'b1, 8'h05, 8'h03, 8'h00);
        send_byte(8'h55);
        wait_idle(20, ok);
        checks++;
        if (drop_cnt - db != 1) begin errors++; $display("FAIL drop_wait pulses=%0d want 1", drop_cnt - db); end
        checks++;
        if (!ok || tx_q.size() != tb + 2 || tx_q[tb] !== 8'h08 || tx_q[tb+1] !== 8'h00) begin
            errors++;
            $display("FAIL drop_tx ok=%b bytes=%0d want 08 00", ok, tx_q.size() - tb);
        end
        send_byte(8'h55);
        @(negedge clk);
        checks++;
        if (drop_cnt - db != 1 || busy !== 1'b0 || en_cnt - eb != 1) begin
            errors++;
            $display("FAIL drop_idle drops=%0d busy=%b issues=%0d want 1 0 1", drop_cnt - db, busy, en_cnt - eb);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int tb = tx_q.size();
        send_byte(8'hCC);
        send_byte(8'h05);
        rst = 1'b0;
        #2;
        checks++;
        if ({alu_en, alu_fun, alu_a, alu_b, tx_p_data, tx_d_vld, busy, err, rx_drop} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs a=%h b=%h fun=%h busy=%b want all 0", alu_a, alu_b, alu_fun, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_a = '0;
        m_b = '0;
        send_byte(8'h07);
        @(negedge clk);
        checks++;
        if (alu_a !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ignore a=%h busy=%b want 00 0", alu_a, busy);
        end
        send_frame(1'b0, 8'h00, 8'h00, 8'h00);
        wait_idle(20, ok);
        checks++;
        if (!ok || en_a !== 8'h00 || en_b !== 8'h00 || tx_q.size() != tb + 2 || tx_q[tb] !== 8'h00 || tx_q[tb+1] !== 8'h00) begin
            errors++;
            $display("FAIL reset_fun_zero ok=%b a=%h b=%h bytes=%0d want 00 00 tx 00 00",
                     ok, en_a, en_b, tx_q.size() - tb);
        end
    endtask

    task automatic test_random;
        bit ok;
        logic [3:0] funs[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
        for (int n = 0; n < 24; n++) begin
            int tb = tx_q.size();
            int eb = en_cnt;
            int db = drop_cnt;
            bit op = ($urandom_range(0, 3) != 0);
            logic [7:0] a = 8'($urandom);
            logic [7:0] b = 8'($urandom);
            logic [3:0] f = funs[$urandom_range(0, 4)];
            logic [7:0] fb = {4'($urandom), f};
            logic [7:0] junk = 8'($urandom);
            logic [15:0] exp_res;
            if (junk == 8'hCC || junk == 8'hDD) junk = 8'h11;
            if ($urandom_range(0, 2) == 0) send_byte(junk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(op, a, b, fb);
            exp_res = alu_calc(m_a, m_b, f);
            wait_idle(20, ok);
            checks++;
            if (!ok || en_cnt - eb != 1 || en_a !== m_a || en_b !== m_b || en_fun !== f) begin
                errors++;
                $display("FAIL rand_issue[%0d] ok=%b n=%0d a=%h b=%h f=%h want 1 %h %h %h",
                         n, ok, en_cnt - eb, en_a, en_b, en_fun, m_a, m_b, f);
            end
            checks++;
            if (tx_q.size() != tb + 2 || drop_cnt != db) begin
                errors++;
                $display("FAIL rand_tx_count[%0d] bytes=%0d drops=%0d want 2 0", n, tx_q.size() - tb, drop_cnt - db);
            end else begin
                checks++;
                if ({tx_q[tb+1], tx_q[tb]} !== exp_res) begin
                    errors++;
                    $display("FAIL rand_tx[%0d] got %h%h want %h", n, tx_q[tb+1], tx_q[tb], exp_res);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_fun();
        test_backpressure();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL full_strobe_total count=%0d want 0", viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded want completion");
        $fatal(1, "bench timeout");
    end

endmodule
